// File: rtl/haar_scan_core.sv
// Scans an integral image held in on-chip RAM with a two-band Haar feature
// (dark eye band above bright cheek band) over all window positions and scales.
module haar_scan_core #(
  parameter int DATA_W     = 32,
  parameter int DIM        = 48,
  parameter int BASE_W     = 12,
  parameter int BASE_H     = 2,
  parameter int NUM_SCALES = 6,
  parameter int EYE_TH     = 212,
  parameter int CHEEK_TH   = 237
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DIM*DIM)-1:0] wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       det_valid,
  input  logic                       det_ready,
  output logic [$clog2(DIM)-1:0]     det_x,
  output logic [$clog2(DIM)-1:0]     det_y,
  output logic [3:0]                 det_scale,
  output logic [31:0]                win_cnt,
  output logic [31:0]                det_cnt
);
  localparam int AW = $clog2(DIM*DIM);
  localparam int XW = $clog2(DIM);
  localparam int CW = 16;
  localparam int LW = 2*DATA_W;
  localparam logic [CW-1:0] LAST = CW'(DIM-1);
  localparam logic [3:0]    NS   = 4'(NUM_SCALES);

  typedef enum logic [2:0] {IDLE, SETUP, READ, EVAL, EMIT, ADVANCE, DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [CW-1:0]     r_x, r_y;
  logic [3:0]        r_s;
  logic [2:0]        r_rd_idx;
  logic [DATA_W-1:0] r_mem [DIM*DIM];
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_c [6];
  logic [XW-1:0]     r_det_x, r_det_y;
  logic [3:0]        r_det_s;
  logic [31:0]       r_win_cnt, r_det_cnt;

  logic              w_busy, w_done, w_det_valid;
  logic [CW-1:0]     w_w, w_h, w_x_max, w_y_max, w_row, w_col;
  logic [LW-1:0]     w_eye_lim, w_cheek_lim;
  logic [DATA_W-1:0] w_eye, w_cheek;
  logic [AW-1:0]     w_rd_addr;
  logic              w_fits, w_last_x, w_last_y, w_scan_end, w_hit, w_wr_ok;

  // Per-scale geometry and threshold limits folded to constants (no runtime multipliers).
  logic [CW-1:0] w_w_tab [16];
  logic [CW-1:0] w_h_tab [16];
  logic [LW-1:0] w_eye_lim_tab [16];
  logic [LW-1:0] w_cheek_lim_tab [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_scale
    localparam int AREA = BASE_W * BASE_H * (gi + 1) * (gi + 1);
    assign w_w_tab[gi]         = CW'(BASE_W * (gi + 1));
    assign w_h_tab[gi]         = CW'(BASE_H * (gi + 1));
    assign w_eye_lim_tab[gi]   = LW'(EYE_TH) * LW'(AREA);
    assign w_cheek_lim_tab[gi] = LW'(CHEEK_TH) * LW'(AREA);
  end

  assign w_w         = w_w_tab[r_s];
  assign w_h         = w_h_tab[r_s];
  assign w_eye_lim   = w_eye_lim_tab[r_s];
  assign w_cheek_lim = w_cheek_lim_tab[r_s];

  assign w_fits     = (w_w <= LAST) && ((w_h << 1) <= LAST);
  assign w_x_max    = LAST - w_w;
  assign w_y_max    = LAST - (w_h << 1);
  assign w_last_x   = (r_x == w_x_max);
  assign w_last_y   = (r_y == w_y_max);
  assign w_scan_end = (r_s >= NS);

  // Corner order: top-left, top-right, mid-left, mid-right, bottom-left, bottom-right.
  always_comb begin
    w_row = r_y;
    w_col = r_x;
    case (r_rd_idx)
      3'd1: w_col = r_x + w_w;
      3'd2: w_row = r_y + w_h;
      3'd3: begin
        w_row = r_y + w_h;
        w_col = r_x + w_w;
      end
      3'd4: w_row = r_y + (w_h << 1);
      3'd5: begin
        w_row = r_y + (w_h << 1);
        w_col = r_x + w_w;
      end
      default: ;
    endcase
  end

  assign w_rd_addr = AW'(32'(w_row) * 32'(DIM) + 32'(w_col));
  assign w_wr_ok   = wr_en && (r_state == IDLE) && (32'(wr_addr) < 32'(DIM*DIM));

  // Image RAM is deliberately outside reset so a reset never loses the loaded image.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[wr_addr] <= wr_data;
    r_rd_data <= r_mem[w_rd_addr];
  end

  assign w_eye   = r_c[3] - r_c[2] - r_c[1] + r_c[0];
  assign w_cheek = r_c[5] - r_c[4] - r_c[3] + r_c[2];
  assign w_hit   = (LW'(w_eye) < w_eye_lim) && (LW'(w_cheek) > w_cheek_lim);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_det_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start) w_state_nxt = SETUP;
      end
      SETUP: begin
        if (w_scan_end)  w_state_nxt = DONE;
        else if (w_fits) w_state_nxt = READ;
      end
      READ:    if (r_rd_idx == 3'd6) w_state_nxt = EVAL;
      EVAL:    w_state_nxt = w_hit ? EMIT : ADVANCE;
      EMIT: begin
        w_det_valid = 1'b1;
        if (det_ready) w_state_nxt = ADVANCE;
      end
      ADVANCE: w_state_nxt = (w_last_x && w_last_y) ? SETUP : READ;
      DONE: begin
        w_busy      = 1'b0;
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) r_c[i] <= '0;
    end else if (r_state == READ && r_rd_idx != 3'd0) begin
      // Data for the read issued last cycle lands in slot idx-1.
      r_c[r_rd_idx - 3'd1] <= r_rd_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x       <= '0;
      r_y       <= '0;
      r_s       <= '0;
      r_rd_idx  <= '0;
      r_det_x   <= '0;
      r_det_y   <= '0;
      r_det_s   <= '0;
      r_win_cnt <= '0;
      r_det_cnt <= '0;
    end else begin
      r_rd_idx <= (r_state == READ && r_rd_idx != 3'd6) ? r_rd_idx + 3'd1 : 3'd0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x       <= '0;
            r_y       <= '0;
            r_s       <= '0;
            r_win_cnt <= '0;
            r_det_cnt <= '0;
          end
        end
        SETUP: if (!w_scan_end && !w_fits) r_s <= r_s + 4'd1;
        EVAL: begin
          r_win_cnt <= r_win_cnt + 32'd1;
          if (w_hit) begin
            r_det_x <= XW'(r_x);
            r_det_y <= XW'(r_y);
            r_det_s <= r_s;
          end
        end
        EMIT: if (det_ready) r_det_cnt <= r_det_cnt + 32'd1;
        ADVANCE: begin
          if (!w_last_x) begin
            r_x <= r_x + 1'b1;
          end else begin
            r_x <= '0;
            if (!w_last_y) begin
              r_y <= r_y + 1'b1;
            end else begin
              r_y <= '0;
              r_s <= r_s + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = w_busy;
  assign done      = w_done;
  assign det_valid = w_det_valid;
  assign det_x     = r_det_x;
  assign det_y     = r_det_y;
  assign det_scale = r_det_s;
  assign win_cnt   = r_win_cnt;
  assign det_cnt   = r_det_cnt;
endmodule

// File: tb/tb_haar_scan_core.sv
// Bench for haar_scan_core: pixel images are turned into integral images, and a
// window-by-window model predicts the detection stream and counters.
`timescale 1ns/1ps
module tb_haar_scan_core;
  localparam int DIM = 16, BW = 6, BH = 1, NS = 2, EYE = 212, CHEEK = 237, N = DIM*DIM;

  logic        clk = 1'b0, reset = 1'b1, wr_en = 1'b0, start = 1'b0, det_ready = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        busy, done, det_valid;
  logic [3:0]  det_x, det_y, det_scale;
  logic [31:0] win_cnt, det_cnt;
  logic        busy3, done3, dv3;
  logic [3:0]  dx3, dy3, ds3;
  logic [31:0] win3, det3;

  always #5 clk = ~clk;

  haar_scan_core #(.DATA_W(32), .DIM(DIM), .BASE_W(BW), .BASE_H(BH), .NUM_SCALES(NS),
                   .EYE_TH(EYE), .CHEEK_TH(CHEEK)) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .det_valid(det_valid), .det_ready(det_ready),
    .det_x(det_x), .det_y(det_y), .det_scale(det_scale), .win_cnt(win_cnt), .det_cnt(det_cnt));

  // Three-scale copy: the third scale never fits, so it must match the two-scale results.
  haar_scan_core #(.DATA_W(32), .DIM(DIM), .BASE_W(BW), .BASE_H(BH), .NUM_SCALES(3),
                   .EYE_TH(EYE), .CHEEK_TH(CHEEK)) u_dut3 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy3), .done(done3), .det_valid(dv3), .det_ready(det_ready),
    .det_x(dx3), .det_y(dy3), .det_scale(ds3), .win_cnt(win3), .det_cnt(det3));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int x; int y; int s; } det_t;
  int     pix [DIM][DIM];
  longint img [N];
  det_t   exp_q [$];
  int     exp_win, exp_det;

  // Integral convention: I(r,c) = sum of pixels with row < r and col < c.
  function automatic void build_model();
    longint ii [DIM][DIM];
    longint eye, cheek, area;
    int w, h;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        if (r == 0 || c == 0) ii[r][c] = 0;
        else ii[r][c] = ii[r-1][c] + ii[r][c-1] - ii[r-1][c-1] + pix[r-1][c-1];
        img[r*DIM + c] = ii[r][c];
      end
    exp_q.delete();
    exp_win = 0;
    for (int s = 0; s < NS; s++) begin
      w = BW * (s + 1);
      h = BH * (s + 1);
      area = w * h;
      for (int y = 0; y + 2*h <= DIM - 1; y++)
        for (int x = 0; x + w <= DIM - 1; x++) begin
          exp_win++;
          eye   = ii[y+h][x+w] - ii[y+h][x] - ii[y][x+w] + ii[y][x];
          cheek = ii[y+2*h][x+w] - ii[y+2*h][x] - ii[y+h][x+w] + ii[y+h][x];
          if (eye < EYE * area && cheek > CHEEK * area) exp_q.push_back('{x, y, s});
        end
    end
    exp_det = exp_q.size();
  endfunction

  // ---------------- compare process ----------------
  bit mon_en = 1'b0, in_scan = 1'b0;
  int done_n = 0, done3_n = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (det_valid) begin
        if (exp_q.size() == 0) chk("det_unexpected", det_valid, 0);
        else begin
          chk("det_x", det_x, exp_q[0].x);
          chk("det_y", det_y, exp_q[0].y);
          chk("det_scale", det_scale, exp_q[0].s);
          if (det_ready) void'(exp_q.pop_front());
        end
      end
      if (in_scan) chk("busy", busy, !done);
      if (done) begin
        done_n++;
        in_scan = 1'b0;
        chk("win_cnt", win_cnt, exp_win);
        chk("det_cnt", det_cnt, exp_det);
        chk("dets_pending", exp_q.size(), 0);
      end
      if (done3) begin
        done3_n++;
        chk("win_cnt_3scale", win3, exp_win);
        chk("det_cnt_3scale", det3, exp_det);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic load_image();
    build_model();
    for (int a = 0; a < N; a++) begin
      wr_en = 1'b1; wr_addr = 8'(a); wr_data = 32'(img[a]);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic rand_image();
    int kind;
    for (int r = 0; r < DIM; r++) begin
      kind = $urandom_range(2);
      for (int c = 0; c < DIM; c++)
        case (kind)
          0: pix[r][c] = 90 + $urandom_range(40);
          1: pix[r][c] = 240 + $urandom_range(15);
          default: pix[r][c] = $urandom_range(255);
        endcase
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: stall the first record 20 cycles
  task automatic run_scan(input int mode, input bit inject);
    int cyc;
    bit stalled;
    longint w0;
    cyc = 0; stalled = 1'b0; w0 = 0;
    build_model();
    done_n = 0; done3_n = 0; mon_en = 1'b1;
    det_ready = (mode != 2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_scan = 1'b1;
    while ((done_n == 0 || done3_n == 0) && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (mode == 1) det_ready = ($urandom_range(3) != 0);
      if (inject && cyc >= 30 && cyc < 40) begin
        start = 1'b1; wr_en = 1'b1;
        wr_addr = 8'($urandom_range(N - 1)); wr_data = $urandom;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      if (mode == 2 && !stalled && det_valid && !det_ready) begin
        stalled = 1'b1;
        w0 = win_cnt;
        chk("stall_det_cnt", det_cnt, 0);
        repeat (20) begin
          @(posedge clk); #1;
          chk("stall_valid", det_valid, 1);
          chk("stall_win_cnt", win_cnt, w0);
        end
        det_ready = 1'b1;
        cyc += 20;
      end
    end
    if (cyc >= 20000) chk("scan_timeout_done", done_n, 1);
    if (mode == 2) chk("stall_seen", stalled, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_n, 1);
    chk("done_once_3scale", done3_n, 1);
    chk("busy_after", busy, 0);
    chk("busy_after_3scale", busy3, 0);
    mon_en = 1'b0; in_scan = 1'b0;
  endtask

  initial begin
    bit seen_done;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_det_valid", det_valid, 0);
    chk("rst_win_cnt", win_cnt, 0);
    chk("rst_det_cnt", det_cnt, 0);
    chk("rst_det_x", det_x, 0);
    reset = 1'b0;

    // all-zero image
    for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) pix[r][c] = 0;
    load_image();
    chk("model_win_total", exp_win, 188);
    run_scan(0, 0);
    chk("zero_img_win", win_cnt, 188);
    chk("zero_img_det", det_cnt, 0);
    chk("zero_img_win_3scale", win3, 188);

    // dark row 1 over bright row 2 at columns 4..9
    for (int c = 4; c <= 9; c++) begin
      pix[1][c] = 100;
      pix[2][c] = 250;
    end
    load_image();
    chk("model_band_dets", exp_q.size(), 1);
    chk("model_band_x", exp_q[0].x, 4);
    chk("model_band_y", exp_q[0].y, 1);
    chk("model_band_s", exp_q[0].s, 0);
    run_scan(0, 0);
    chk("band_det_cnt", det_cnt, 1);
    chk("band_det_x", det_x, 4);
    chk("band_det_y", det_y, 1);
    run_scan(2, 0);

    // random banded images; second one also hammers start/wr_en while busy
    for (int k = 0; k < 3; k++) begin
      rand_image();
      load_image();
      run_scan(1, k == 1);
      if (k == 1) run_scan(1, 0);
    end

    // reset 50 cycles into a scan
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #3;
    chk("pre_reset_win_nonzero", win_cnt != 0, 1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_det_valid", det_valid, 0);
    chk("midrst_win_cnt", win_cnt, 0);
    chk("midrst_det_cnt", det_cnt, 0);
    chk("midrst_det_x", det_x, 0);
    chk("midrst_det_scale", det_scale, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      seen_done |= done;
    end
    chk("no_done_after_reset", seen_done, 0);
    chk("idle_after_reset", busy, 0);
    run_scan(1, 0);
    chk("rescan_win", win_cnt, 188);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
